// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-to-datapath bundle for the multicycle RISC-V controller
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       Opcode;
   logic             Zero;
   logic             MemReady;
   logic             IRWrite;
   logic             PCWrite;
   logic             PCSrc;
   logic             IorD;
   logic             MemRead;
   logic             MemWrite;
   logic             RegWrite;
   logic             MemtoReg;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic             Illegal;
   logic [3:0]       State;
   logic [CNT_W-1:0] Retired;

   modport master (
      input  Opcode, Zero, MemReady,
      output IRWrite, PCWrite, PCSrc, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
      output ALUSrcA, ALUSrcB, ALUOp, Illegal, State, Retired
   );

   modport slave (
      output Opcode, Zero, MemReady,
      input  IRWrite, PCWrite, PCSrc, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
      input  ALUSrcA, ALUSrcB, ALUOp, Illegal, State, Retired
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the non-pipelined multicycle RISC-V datapath
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_TRAP   = 4'd10;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;
   logic             retire;

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC;
               OP_BEQ:            state_d = S_BRANCH;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: state_d = (bus.Opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
   end

   // An instruction retires on the edge that leaves its last state.
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                   ((state_q == S_MEMWR) && bus.MemReady);
   assign retired_d = retired_q + CNT_W'(retire);
   assign illegal_d = illegal_q | (state_d == S_TRAP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.PCSrc    = 1'b0;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.ALUSrcA  = 2'b00;
      bus.ALUSrcB  = 2'b00;
      bus.ALUOp    = 2'b00;
      case (state_q)
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.MemReady;
            bus.PCWrite = bus.MemReady;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         S_EXEC: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUOp   = 2'b10;
         end
         S_ALUWB:  bus.RegWrite = 1'b1;
         S_BRANCH: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUOp   = 2'b01;
            bus.PCSrc   = 1'b1;
            bus.PCWrite = bus.Zero;
         end
         default: ;
      endcase
   end

   assign bus.Illegal = illegal_q;
   assign bus.State   = state_q;
   assign bus.Retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;
   localparam int CNT_W = 4;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_TRAP   = 4'd10;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_BAD   = 7'b0010011;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if #(.CNT_W(CNT_W)) bus ();
   multicycle_control #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int               n_vec = 0;
   int               n_bad = 0;
   bit               exp_valid = 1'b0;
   logic [18:0]      exp_vec;
   logic [CNT_W-1:0] exp_ret;
   int               ret = 0;
   int               step = 0;
   logic [6:0]       cur_op = OP_R;

   wire [18:0] act_vec = {bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.IorD, bus.MemRead,
                          bus.MemWrite, bus.RegWrite, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
                          bus.ALUOp, bus.Illegal, bus.State};

   // Strobe table by state name, straight from the control description.
   function automatic logic [18:0] exp_outputs(input logic [3:0] st, input logic mr, input logic z);
      logic irw, pcw, pcsrc, iord, mrd, mwr, rw, m2r, ill;
      logic [1:0] a, b, op;
      {irw, pcw, pcsrc, iord, mrd, mwr, rw, m2r, ill} = '0;
      {a, b, op} = '0;
      case (st)
         S_FETCH:  begin mrd = 1; b = 2'b01; irw = mr; pcw = mr; end
         S_DECODE: begin a = 2'b10; b = 2'b10; end
         S_MEMADR: begin a = 2'b01; b = 2'b10; end
         S_MEMRD:  begin mrd = 1; iord = 1; end
         S_MEMWB:  begin rw = 1; m2r = 1; end
         S_MEMWR:  begin mwr = 1; iord = 1; end
         S_EXEC:   begin a = 2'b01; b = 2'b00; op = 2'b10; end
         S_ALUWB:  rw = 1;
         S_BRANCH: begin a = 2'b01; op = 2'b01; pcsrc = 1; pcw = z; end
         S_TRAP:   ill = 1;
         default: ;
      endcase
      return {irw, pcw, pcsrc, iord, mrd, mwr, rw, m2r, a, b, op, ill, st};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock of stimulus: the DUT is expected to sit in st for this cycle.
   task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic rst,
                      input bit chk);
      @(posedge clk);
      #1;
      bus.MemReady = mr;
      bus.Zero     = z;
      bus.Opcode   = cur_op;
      reset        = rst;
      exp_vec      = exp_outputs(st, mr, z);
      exp_ret      = ret[CNT_W-1:0];
      exp_valid    = chk;
      step++;
      if (rst) ret = 0;
      else if (st == S_MEMWB || st == S_ALUWB || st == S_BRANCH || (st == S_MEMWR && mr))
         ret = (ret + 1) % (1 << CNT_W);
   endtask

   task automatic do_reset(input logic [3:0] cur, input bit chk);
      cyc(cur, rb(), rb(), 1'b1, chk);
      cyc(S_IDLE, rb(), rb(), 1'b0, 1'b1);
   endtask

   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                            output int n);
      n = 0;
      repeat (fw) begin cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1); n++; end
      cyc(S_FETCH, 1'b1, rb(), 1'b0, 1'b1); n++;
      cur_op = op;
      cyc(S_DECODE, rb(), rb(), 1'b0, 1'b1); n++;
      case (op)
         OP_LOAD: begin
            cyc(S_MEMADR, rb(), rb(), 1'b0, 1'b1); n++;
            repeat (mw) begin cyc(S_MEMRD, 1'b0, rb(), 1'b0, 1'b1); n++; end
            cyc(S_MEMRD, 1'b1, rb(), 1'b0, 1'b1); n++;
            cyc(S_MEMWB, rb(), rb(), 1'b0, 1'b1); n++;
         end
         OP_STORE: begin
            cyc(S_MEMADR, rb(), rb(), 1'b0, 1'b1); n++;
            repeat (mw) begin cyc(S_MEMWR, 1'b0, rb(), 1'b0, 1'b1); n++; end
            cyc(S_MEMWR, 1'b1, rb(), 1'b0, 1'b1); n++;
         end
         OP_R: begin
            cyc(S_EXEC, rb(), rb(), 1'b0, 1'b1); n++;
            cyc(S_ALUWB, rb(), rb(), 1'b0, 1'b1); n++;
         end
         OP_BEQ: begin
            cyc(S_BRANCH, rb(), z, 1'b0, 1'b1); n++;
         end
         default: begin
            repeat (20) begin cyc(S_TRAP, rb(), rb(), 1'b0, 1'b1); n++; end
         end
      endcase
   endtask

   initial begin
      int n;
      logic [6:0] op;
      bus.Opcode   = cur_op;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (exp_valid) begin
               n_vec++;
               if (act_vec !== exp_vec) begin
                  n_bad++;
                  $display("FAIL ctl step %0d: got %b expected %b", step, act_vec, exp_vec);
               end
               n_vec++;
               if (bus.Retired !== exp_ret) begin
                  n_bad++;
                  $display("FAIL retired step %0d: got %0d expected %0d", step, bus.Retired, exp_ret);
               end
            end
         end
      join_none

      do_reset(S_IDLE, 1'b0);
      check("reset_state", int'(bus.State), 0);
      check("reset_retired", int'(bus.Retired), 0);

      run_instr(OP_R, 0, 0, 1'b0, n);
      check("rtype_latency", n, 4);
      cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1);
      check("rtype_retired", int'(bus.Retired), 1);

      run_instr(OP_LOAD, 2, 3, 1'b0, n);
      check("load_wait_latency", n, 10);
      run_instr(OP_LOAD, 0, 0, 1'b0, n);
      check("load_latency", n, 5);
      run_instr(OP_STORE, 0, 4, 1'b0, n);
      check("store_wait_latency", n, 8);
      run_instr(OP_STORE, 0, 0, 1'b0, n);
      check("store_latency", n, 4);
      run_instr(OP_BEQ, 0, 0, 1'b1, n);
      check("beq_latency", n, 3);
      run_instr(OP_BEQ, 0, 0, 1'b0, n);
      cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1);
      check("retired_after_seven", int'(bus.Retired), 7);

      run_instr(OP_BAD, 0, 0, 1'b0, n);
      check("trap_illegal", int'(bus.Illegal), 1);
      check("trap_retired", int'(bus.Retired), 7);
      do_reset(S_TRAP, 1'b1);
      check("trap_reset_illegal", int'(bus.Illegal), 0);
      check("trap_reset_retired", int'(bus.Retired), 0);

      run_instr(OP_R, 1, 0, 1'b0, n);
      cyc(S_FETCH, 1'b1, rb(), 1'b0, 1'b1);
      cur_op = OP_STORE;
      cyc(S_DECODE, rb(), rb(), 1'b0, 1'b1);
      cyc(S_MEMADR, rb(), rb(), 1'b0, 1'b1);
      cyc(S_MEMWR, 1'b0, rb(), 1'b0, 1'b1);
      cyc(S_MEMWR, 1'b0, rb(), 1'b1, 1'b1);
      cyc(S_IDLE, 1'b0, rb(), 1'b0, 1'b1);
      check("midwait_reset_state", int'(bus.State), 0);
      check("midwait_reset_memwrite", int'(bus.MemWrite), 0);
      check("midwait_reset_retired", int'(bus.Retired), 0);

      for (int k = 1; k <= 16; k++) begin
         run_instr(OP_R, int'($urandom_range(2, 0)), 0, 1'b0, n);
      end
      cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1);
      check("wrap_after_16", int'(bus.Retired), 0);
      run_instr(OP_R, 0, 0, 1'b0, n);
      cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1);
      check("wrap_after_17", int'(bus.Retired), 1);

      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(3, 0))
            0:       op = OP_LOAD;
            1:       op = OP_STORE;
            2:       op = OP_R;
            default: op = OP_BEQ;
         endcase
         run_instr(op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rb(), n);
      end
      cyc(S_FETCH, 1'b0, rb(), 1'b0, 1'b1);
      check("random_retired", int'(bus.Retired), ret);

      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the non-pipelined multicycle RISC-V datapath; the producer of the 2-bit ALUOp consumed by the ALU control decoder, plus all datapath mux, register-file and memory strobes. Decodes the 7-bit opcode of the latched instruction and steps each instruction through fetch/decode/execute/memory/writeback. Handshakes a single shared instruction/data memory through a ready signal, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; priority over all other inputs
Opcode  in  7  IR[6:0]; stable from the DECODE state until the next FETCH completes
Zero  in  1  ALU zero flag, valid in the BRANCH state
MemReady  in  1  memory completes the current read/write this cycle
IRWrite  out  1  load instruction register and OldPC
PCWrite  out  1  load PC
PCSrc  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register-file write enable
MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
ALUSrcA  out  2  00 = PC, 01 = reg A, 10 = OldPC
ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = immediate
ALUOp  out  2  00 = add, 01 = subtract (beq), 10 = R-type, decode by funct fields
Illegal  out  1  sticky unsupported-opcode flag
State  out  4  current state encoding, for debug
Retired  out  CNT_W  retired-instruction count

Behaviour:
- States, with their encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, TRAP=10. Codes 11-15 are unreachable and go to IDLE.
- Outputs are decoded from State. IRWrite, PCWrite and Retired depend on the inputs as noted. Outputs not listed for a state are 0.
- Reset: at the edge with reset=1, State=IDLE, Retired=0 and Illegal=0. In IDLE all outputs are 0. Any outstanding memory request is abandoned.
- IDLE: no outputs asserted. Goes to FETCH on the next clock.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=MemReady, so PC <= PC+4 only on completion. Stays in FETCH while MemReady=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00, so ALUOut = OldPC+imm (branch target). Next state by Opcode:
  - 0000011 (load) or 0100011 (store) -> MEMADR
  - 0110011 (R-type) -> EXEC
  - 1100011 (beq) -> BRANCH
  - any other value -> TRAP
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEMRD if Opcode is load, MEMWR if store.
- MEMRD: MemRead=1, IorD=1. Waits for MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Goes to FETCH and retires.
- MEMWR: MemWrite=1, IorD=1. Waits for MemReady, then goes to FETCH and retires.
- EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0. Goes to FETCH and retires.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero. Goes to FETCH and retires whether or not the branch is taken.
- TRAP: Illegal=1. Stays in TRAP until reset and never retires.
- Retire: Retired increments by 1 on the edge that leaves MEMWB, ALUWB or BRANCH, or leaves MEMWR with MemReady=1. It wraps from 2^CNT_W-1 to 0.
- Request stability: MemRead, MemWrite and IorD stay constant throughout a wait. A MemReady pulse in any state other than FETCH, MEMRD or MEMWR is ignored.
- Latency with zero-wait memory:
  - load: 5 cycles
  - store: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
  - Each memory wait cycle adds exactly 1 cycle.
- Reset has priority mid-instruction, including during a memory wait: next State=IDLE and no write strobe is asserted after that edge.

Test Plan:
- Reset then an R-type instruction (Opcode=0110011, MemReady=1): states IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH. ALUOp=10 in EXEC; RegWrite=1, MemtoReg=0 in ALUWB; Retired goes 0 -> 1.
- Load with 2 wait cycles in FETCH and 3 in MEMRD: MemRead stays 1 and IorD stays fixed across the waits. IRWrite/PCWrite pulse exactly once. MEMWB asserts RegWrite and MemtoReg. Total 10 cycles from FETCH entry; Retired increments by 1.
- Store (0100011) with MemReady=0 for 4 cycles in MEMWR: MemWrite=1 for 5 cycles, RegWrite stays 0, then FETCH. beq with Zero=1: PCWrite=1, PCSrc=1, ALUOp=01. beq with Zero=0: PCWrite=0. Both beq cases retire.
- Opcode=0010011 in DECODE: TRAP, Illegal=1 held for 20 cycles, no strobes, Retired unchanged. Then assert reset: IDLE, Illegal=0, Retired=0.
- Assert reset during MEMWR with MemReady=0: next State=IDLE, MemWrite=0, Retired=0.
- CNT_W=4: run 17 R-type instructions back-to-back; Retired reads 0 after the 16th and 1 after the 17th.
